// File: rtl/time_counter_gen_if.sv
// Bundle of control, time-load handshake and display signals for time_counter_gen.
// DAY_COUNT_EN adds the 16-bit DAY_CNT output.
interface time_counter_gen_if;
    logic       TICK_EN;
    logic       RUN;
    logic       MODE_12H;
    logic       SET_VALID;
    logic       SET_READY;
    logic [4:0] SET_HOUR;
    logic [5:0] SET_MIN;
    logic [5:0] SET_SEC;
    logic       SET_ERR;
    logic [4:0] HOUR;
    logic [5:0] MIN;
    logic [5:0] SEC;
    logic [3:0] H10;
    logic [3:0] H1;
    logic [3:0] M10;
    logic [3:0] M1;
    logic [3:0] S10;
    logic [3:0] S1;
    logic       PM;
    logic       SEC_PULSE;
`ifdef DAY_COUNT_EN
    logic [15:0] DAY_CNT;
`endif

    modport master (
        output TICK_EN, RUN, MODE_12H, SET_VALID, SET_HOUR, SET_MIN, SET_SEC,
        input  SET_READY, SET_ERR, HOUR, MIN, SEC, H10, H1, M10, M1, S10, S1,
               PM, SEC_PULSE
`ifdef DAY_COUNT_EN
        , input DAY_CNT
`endif
    );

    modport slave (
        input  TICK_EN, RUN, MODE_12H, SET_VALID, SET_HOUR, SET_MIN, SET_SEC,
        output SET_READY, SET_ERR, HOUR, MIN, SEC, H10, H1, M10, M1, S10, S1,
               PM, SEC_PULSE
`ifdef DAY_COUNT_EN
        , output DAY_CNT
`endif
    );
endinterface

// File: rtl/time_counter_gen.sv
// HH:MM:SS time-of-day counter with prescaler, validated time-set load and BCD display outputs.
// Define DAY_COUNT_EN to add the DAY_CNT day counter.
module time_counter_gen #(
    parameter int TICKS_PER_SEC = 100,
    parameter int PRE_W         = 7
) (
    input logic               CLK,
    input logic               RESET,
    time_counter_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CHECK, LOAD, ERR} state_t;

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_SEC - 1);

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [4:0]       hour_q, hour_d;
    logic [5:0]       min_q, min_d;
    logic [5:0]       sec_q, sec_d;
    logic [4:0]       cap_hour_q, cap_hour_d;
    logic [5:0]       cap_min_q, cap_min_d;
    logic [5:0]       cap_sec_q, cap_sec_d;
    logic             set_err_q, set_err_d;
    logic             sec_pulse_q, sec_pulse_d;
    logic             tick;
`ifdef DAY_COUNT_EN
    logic [15:0]      day_q, day_d;
`endif

    always_comb begin
        state_d     = state_q;
        pre_d       = pre_q;
        hour_d      = hour_q;
        min_d       = min_q;
        sec_d       = sec_q;
        cap_hour_d  = cap_hour_q;
        cap_min_d   = cap_min_q;
        cap_sec_d   = cap_sec_q;
        set_err_d   = 1'b0;
        sec_pulse_d = 1'b0;
        tick        = 1'b0;
`ifdef DAY_COUNT_EN
        day_d       = day_q;
`endif

        case (state_q)
            IDLE: begin
                // An accepted load freezes the prescaler in the same cycle, so it beats a tick
                if (bus.SET_VALID) begin
                    cap_hour_d = bus.SET_HOUR;
                    cap_min_d  = bus.SET_MIN;
                    cap_sec_d  = bus.SET_SEC;
                    state_d    = CHECK;
                end else if (bus.TICK_EN && bus.RUN) begin
                    if (pre_q == PRE_MAX) begin
                        pre_d = '0;
                        tick  = 1'b1;
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end
            end
            CHECK: begin
                if (cap_hour_q <= 5'd23 && cap_min_q <= 6'd59 && cap_sec_q <= 6'd59) begin
                    state_d = LOAD;
                end else begin
                    state_d   = ERR;
                    set_err_d = 1'b1;
                end
            end
            LOAD: begin
                hour_d  = cap_hour_q;
                min_d   = cap_min_q;
                sec_d   = cap_sec_q;
                pre_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (tick) begin
            sec_pulse_d = 1'b1;
            if (sec_q == 6'd59) begin
                sec_d = '0;
                if (min_q == 6'd59) begin
                    min_d = '0;
                    if (hour_q == 5'd23) begin
                        hour_d = '0;
`ifdef DAY_COUNT_EN
                        day_d  = day_q + 16'd1;
`endif
                    end else begin
                        hour_d = hour_q + 5'd1;
                    end
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            pre_q       <= '0;
            hour_q      <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            cap_hour_q  <= '0;
            cap_min_q   <= '0;
            cap_sec_q   <= '0;
            set_err_q   <= 1'b0;
            sec_pulse_q <= 1'b0;
`ifdef DAY_COUNT_EN
            day_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            cap_hour_q  <= cap_hour_d;
            cap_min_q   <= cap_min_d;
            cap_sec_q   <= cap_sec_d;
            set_err_q   <= set_err_d;
            sec_pulse_q <= sec_pulse_d;
`ifdef DAY_COUNT_EN
            day_q       <= day_d;
`endif
        end
    end

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] t;
        logic [5:0] r;
        t = 4'd0;
        r = v;
        for (int k = 0; k < 6; k++) begin
            if (r >= 6'd10) begin
                r = r - 6'd10;
                t = t + 4'd1;
            end
        end
        return {t, r[3:0]};
    endfunction

    // 12-hour display: 0 shows as 12, 13..23 fold down to 1..11
    logic [4:0] hour_disp;
    always_comb begin
        hour_disp = hour_q;
        if (bus.MODE_12H) begin
            if (hour_q == 5'd0)
                hour_disp = 5'd12;
            else if (hour_q > 5'd12)
                hour_disp = hour_q - 5'd12;
        end
    end

    logic [5:0] bin_val [3];
    logic [3:0] tens    [3];
    logic [3:0] ones    [3];

    assign bin_val[0] = {1'b0, hour_disp};
    assign bin_val[1] = min_q;
    assign bin_val[2] = sec_q;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_bcd
            assign {tens[gi], ones[gi]} = to_bcd(bin_val[gi]);
        end
    endgenerate

    assign bus.H10       = tens[0];
    assign bus.H1        = ones[0];
    assign bus.M10       = tens[1];
    assign bus.M1        = ones[1];
    assign bus.S10       = tens[2];
    assign bus.S1        = ones[2];
    assign bus.HOUR      = hour_q;
    assign bus.MIN       = min_q;
    assign bus.SEC       = sec_q;
    assign bus.PM        = (hour_q >= 5'd12);
    assign bus.SET_READY = (state_q == IDLE);
    assign bus.SET_ERR   = set_err_q;
    assign bus.SEC_PULSE = sec_pulse_q;
`ifdef DAY_COUNT_EN
    assign bus.DAY_CNT   = day_q;
`endif
endmodule

// File: tb/tb_time_counter_gen.sv
// Randomized self-checking bench for time_counter_gen against a seconds-of-day reference model.
// Define DAY_COUNT_EN to also check DAY_CNT.
module tb_time_counter_gen;
    localparam int TPS = 100;

    logic clk;
    logic rst;
    time_counter_gen_if bus();

    time_counter_gen #(.TICKS_PER_SEC(TPS), .PRE_W(7)) dut (
        .CLK(clk), .RESET(rst), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: time as seconds of day, prescaler as an integer,
    // and the load as a count of busy cycles before the block accepts again.
    int m_tod, m_pre, m_busy, m_pend, m_day;
    bit m_ok, m_err, m_pulse;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tod = 0; m_pre = 0; m_busy = 0; m_pend = 0; m_day = 0;
        m_ok = 0; m_err = 0; m_pulse = 0;
    endtask

    task automatic model_edge();
        m_err = 0;
        m_pulse = 0;
        if (m_busy == 2) begin
            m_busy = 1;
            m_err  = !m_ok;
        end else if (m_busy == 1) begin
            m_busy = 0;
            if (m_ok) begin
                m_tod = m_pend;
                m_pre = 0;
            end
        end else if (bus.SET_VALID) begin
            m_ok   = (bus.SET_HOUR < 24) && (bus.SET_MIN < 60) && (bus.SET_SEC < 60);
            m_pend = bus.SET_HOUR * 3600 + bus.SET_MIN * 60 + bus.SET_SEC;
            m_busy = 2;
        end else if (bus.TICK_EN && bus.RUN) begin
            m_pre++;
            if (m_pre == TPS) begin
                m_pre   = 0;
                m_tod   = (m_tod + 1) % 86400;
                m_pulse = 1;
                if (m_tod == 0) m_day = (m_day + 1) % 65536;
            end
        end
    endtask

    task automatic compare_all();
        int h, m, s, hd;
        logic [31:0] dig_exp, dig_obs;
        h  = m_tod / 3600;
        m  = (m_tod / 60) % 60;
        s  = m_tod % 60;
        hd = bus.MODE_12H ? ((h + 11) % 12) + 1 : h;
        dig_exp = ((hd / 10) << 20) | ((hd % 10) << 16) | ((m / 10) << 12) |
                  ((m % 10) << 8) | ((s / 10) << 4) | (s % 10);
        dig_obs = {8'd0, bus.H10, bus.H1, bus.M10, bus.M1, bus.S10, bus.S1};
        check("hour", 32'(bus.HOUR), h);
        check("min", 32'(bus.MIN), m);
        check("sec", 32'(bus.SEC), s);
        check("digits", dig_obs, dig_exp);
        check("pm", 32'(bus.PM), (h >= 12) ? 1 : 0);
        check("ready", 32'(bus.SET_READY), (m_busy == 0) ? 1 : 0);
        check("set_err", 32'(bus.SET_ERR), 32'(m_err));
        check("sec_pulse", 32'(bus.SEC_PULSE), 32'(m_pulse));
`ifdef DAY_COUNT_EN
        check("day_cnt", 32'(bus.DAY_CNT), m_day);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #2;
        compare_all();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        compare_all();
    endtask

    task automatic set_time(input int h, input int m, input int s);
        int budget;
        budget = 20;
        while (!bus.SET_READY && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) check("ready_timeout", 32'(bus.SET_READY), 1);
        bus.SET_VALID = 1'b1;
        bus.SET_HOUR  = 5'(h);
        bus.SET_MIN   = 6'(m);
        bus.SET_SEC   = 6'(s);
        step();
        bus.SET_VALID = 1'b0;
        check("load_ready_lo1", 32'(bus.SET_READY), 0);
        step();
        check("load_ready_lo2", 32'(bus.SET_READY), 0);
        step();
        check("load_ready_hi", 32'(bus.SET_READY), 1);
    endtask

    int saved_tod;
    int saved_day;

    initial begin
        bus.TICK_EN = 1'b1; bus.RUN = 1'b1; bus.MODE_12H = 1'b0; bus.SET_VALID = 1'b0;
        bus.SET_HOUR = '0; bus.SET_MIN = '0; bus.SET_SEC = '0;
        do_reset();

        // Reset mid-count, then first second after release
        repeat (137) step();
        do_reset();
        check("rst_ready", 32'(bus.SET_READY), 1);
        check("rst_sec", 32'(bus.SEC), 0);
        repeat (99) step();
        check("sec_before_100", 32'(bus.SEC), 0);
        step();
        check("sec_at_100", 32'(bus.SEC), 1);
        check("pulse_at_100", 32'(bus.SEC_PULSE), 1);
        step();
        check("pulse_one_cycle", 32'(bus.SEC_PULSE), 0);

        // Full-day rollover
        set_time(23, 59, 59);
        saved_day = m_day;
        repeat (100) step();
        check("roll_digits", {8'd0, bus.H10, bus.H1, bus.M10, bus.M1, bus.S10, bus.S1}, 0);
        check("roll_hour", 32'(bus.HOUR), 0);
        check("roll_pm", 32'(bus.PM), 0);
`ifdef DAY_COUNT_EN
        check("roll_day", 32'(bus.DAY_CNT), saved_day + 1);
`endif

        // Valid load 13:05:42 in both display modes
        set_time(13, 5, 42);
        check("load_hour", 32'(bus.HOUR), 13);
        check("load_min", 32'(bus.MIN), 5);
        check("load_sec", 32'(bus.SEC), 42);
        bus.MODE_12H = 1'b1;
        #1;
        check("12h_h10", 32'(bus.H10), 0);
        check("12h_h1", 32'(bus.H1), 1);
        check("12h_pm", 32'(bus.PM), 1);
        check("12h_hour", 32'(bus.HOUR), 13);
        bus.MODE_12H = 1'b0;
        #1;
        check("24h_h10", 32'(bus.H10), 1);
        check("24h_h1", 32'(bus.H1), 3);
        repeat (99) step();
        check("prescaler_cleared", 32'(bus.SEC), 42);
        step();
        check("first_tick_after_load", 32'(bus.SEC), 43);

        // Invalid loads leave time untouched
        saved_tod = m_tod;
        set_time(24, 0, 0);
        check("bad_hour_keep", 32'(bus.HOUR), saved_tod / 3600);
        saved_tod = m_tod;
        bus.SET_VALID = 1'b1; bus.SET_HOUR = 5'd10; bus.SET_MIN = 6'd60; bus.SET_SEC = 6'd0;
        step();
        bus.SET_VALID = 1'b0;
        check("bad_min_err_lo", 32'(bus.SET_ERR), 0);
        step();
        check("bad_min_err_hi", 32'(bus.SET_ERR), 1);
        step();
        check("bad_min_err_clr", 32'(bus.SET_ERR), 0);
        check("bad_min_keep", 32'(bus.MIN), (saved_tod / 60) % 60);

        // Tick/load collision with the prescaler at its last count
        set_time(1, 2, 3);
        repeat (99) step();
        bus.SET_VALID = 1'b1; bus.SET_HOUR = 5'd4; bus.SET_MIN = 6'd5; bus.SET_SEC = 6'd6;
        step();
        bus.SET_VALID = 1'b0;
        check("coll_no_pulse", 32'(bus.SEC_PULSE), 0);
        check("coll_sec_held", 32'(bus.SEC), 3);
        step();
        step();
        check("coll_loaded", 32'(bus.SEC), 6);
        check("coll_no_pulse2", 32'(bus.SEC_PULSE), 0);

        // Freeze holds the prescaler mid-second
        set_time(0, 0, 0);
        repeat (50) step();
        bus.RUN = 1'b0;
        repeat (500) step();
        check("freeze_sec", 32'(bus.SEC), 0);
        bus.RUN = 1'b1;
        repeat (49) step();
        check("resume_sec_before", 32'(bus.SEC), 0);
        step();
        check("resume_sec", 32'(bus.SEC), 1);

        // Held SET_VALID re-accepts right after completion
        bus.SET_VALID = 1'b1; bus.SET_HOUR = 5'd7; bus.SET_MIN = 6'd8; bus.SET_SEC = 6'd9;
        repeat (6) step();
        bus.SET_VALID = 1'b0;
        repeat (3) step();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bus.TICK_EN  = ($urandom_range(0, 9) != 0);
            bus.RUN      = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 49) == 0) bus.MODE_12H = ~bus.MODE_12H;
            bus.SET_VALID = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 1) == 0) begin
                bus.SET_HOUR = 5'd23; bus.SET_MIN = 6'd59;
                bus.SET_SEC  = 6'($urandom_range(55, 59));
            end else begin
                bus.SET_HOUR = 5'($urandom_range(0, 31));
                bus.SET_MIN  = 6'($urandom_range(0, 63));
                bus.SET_SEC  = 6'($urandom_range(0, 63));
            end
            if ($urandom_range(0, 1499) == 0) do_reset();
            else step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/time_counter_gen.md
Name: time_counter_gen

Overview:
Parametrised successor to the fixed 100-tick HH:MM:SS counter.
- Divides a qualified tick stream into seconds, minutes and hours.
- Runs in 24-hour internal time, with a selectable 12/24-hour display format.
- Accepts a validated time-set load through a valid/ready handshake.
- Provides binary and BCD-digit outputs that feed the display decoders and the alarm comparator.

Parameters:
- TICKS_PER_SEC, 100: TICK_EN-qualified cycles per second; must be >= 2.
- PRE_W, 7: prescaler width; must satisfy 2^PRE_W >= TICKS_PER_SEC.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- TICK_EN  in  1  prescaler advance qualifier.
- RUN  in  1  1 = time advances; 0 = frozen with prescaler held.
- MODE_12H  in  1  display format; 1 = 12-hour, 0 = 24-hour.
- SET_VALID  in  1  time-load request.
- SET_READY  out  1  block can accept a load.
- SET_HOUR  in  5  load hour, 0..23.
- SET_MIN  in  6  load minute, 0..59.
- SET_SEC  in  6  load second, 0..59.
- SET_ERR  out  1  one-cycle pulse when a load is rejected.
- HOUR  out  5  binary hour, always 24-hour.
- MIN  out  6  binary minute.
- SEC  out  6  binary second.
- H10, H1, M10, M1, S10, S1  out  4 each  BCD display digits.
- PM  out  1  1 when HOUR >= 12, in either mode.
- SEC_PULSE  out  1  one-cycle pulse on every second increment.

Behaviour:
- Reset: the following outputs and state clear to 0: prescaler, HOUR, MIN, SEC, SET_ERR, SEC_PULSE, FSM state (IDLE). SET_READY resets to 1.
- Prescaler: on each CLK where TICK_EN=1, RUN=1 and FSM=IDLE, it increments. At TICKS_PER_SEC-1 it wraps to 0 and generates the internal tick. When RUN=0 it holds its value; time does not advance.
- Tick cascade, registered with the tick:
  - SEC increments and wraps 59->0.
  - MIN increments only when SEC=59, and wraps 59->0.
  - HOUR increments only when MIN=59 and SEC=59, and wraps 23->0.
  - SEC_PULSE is 1 in the cycle after the tick edge, i.e. aligned with the new SEC value.
- Set FSM:
  - IDLE (SET_READY=1): when SET_VALID=1, capture SET_* and go to CHECK.
  - CHECK (SET_READY=0): range-check the captured values. If all are in range go to LOAD, otherwise go to ERR.
  - LOAD: write HOUR/MIN/SEC from the captured values, clear the prescaler, return to IDLE.
  - ERR: pulse SET_ERR for one cycle, leave time unchanged, return to IDLE.
  - Latency: the new time is visible 2 cycles after the accepting edge. SET_READY is low for exactly 2 cycles.
- Collisions:
  - A tick that would occur during CHECK, LOAD or ERR is suppressed, because the prescaler is frozen outside IDLE.
  - A load always wins over a tick.
  - SET_VALID held high re-accepts in the first IDLE cycle after the previous load completes.
- BCD outputs: combinational from HOUR/MIN/SEC.
  - 24-hour mode: H10/H1 show HOUR directly.
  - 12-hour mode: hour 0 displays 12, 1..12 display 1..12, 13..23 display 1..11.
  - Leading zero is kept: H10=0 for single-digit hours.
- Changing MODE_12H affects display only. It never alters HOUR, the prescaler, or PM.
- Reset asserted mid-load: FSM returns to IDLE, the load is discarded, and all values take their reset values.

Optional Feature:
- DAY_COUNT_EN defined: adds output port DAY_CNT, 16 bits.
  - Reset value 0.
  - Increments in the same cycle HOUR wraps 23->0 via the tick cascade.
  - Wraps 65535->0.
  - A set load never changes it.
- DAY_COUNT_EN undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset check: pulse RESET mid-count with RUN=1 and TICK_EN=1 for all cycles -> all time outputs 0 and SET_READY=1 on release. After 100 TICK_EN cycles, SEC=1 and SEC_PULSE=1 for one cycle.
- Full-day rollover: load 23:59:59, then apply 100 ticks -> 00:00:00, H10=H1=M10=M1=S10=S1=0, PM=0. DAY_CNT increments by 1 when DAY_COUNT_EN is defined.
- Valid load: SET_VALID with 13:05:42 -> SET_READY low for 2 cycles, then HOUR=13 and prescaler=0. With MODE_12H=1 -> H10=0, H1=1, PM=1. With MODE_12H=0 -> H10=1, H1=3.
- Invalid load: SET_VALID with 24:00:00 or 10:60:00 -> SET_ERR high for exactly one cycle and time unchanged.
- Tick/load collision: assert SET_VALID when prescaler=99 and TICK_EN=1 -> no increment occurs, loaded value appears, and SEC_PULSE stays 0.
- Freeze: RUN=0 for 500 cycles -> SEC and prescaler hold. On RUN=1, counting resumes from the held prescaler value.
